// File: rtl/rand_pkg.sv
// Shared definitions for the range-limited LFSR random source:
// FSM state type, Galois tap masks per supported width and a clog2 helper.
package rand_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // Right-shift Galois feedback masks: when the bit shifted out of bit 0 is 1,
  // the register is XORed with this mask. All are maximal-length polynomials.
  // A return value of zero marks an unsupported width.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      16:      taps = 32'h0000_B400;
      24:      taps = 32'h00E1_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

  // Ceiling log2; returns 0 for values <= 1 so a one-value range needs no bits.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/lfsr_rand_range_if.sv
// Request/result bundle between the game FSM (master) and the random source (slave).
interface lfsr_rand_range_if #(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 3
);

  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic              req;
  logic [OUT_W-1:0]  rand_out;
  logic              rand_valid;
  logic              busy;
  logic              fallback;

  // Game FSM side: issues requests and optional reseeds, consumes results.
  modport master (
    output seed_load,
    output seed_in,
    output req,
    input  rand_out,
    input  rand_valid,
    input  busy,
    input  fallback
  );

  // Random source side.
  modport slave (
    input  seed_load,
    input  seed_in,
    input  req,
    output rand_out,
    output rand_valid,
    output busy,
    output fallback
  );

endinterface

// File: rtl/lfsr_core.sv
// Free-running right-shift Galois LFSR with a synchronous load.
// A zero load value would lock the register at zero, so it is replaced by SEED.
module lfsr_core
  import rand_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_core: SEED must be nonzero");
  end

  if (TAPS == '0) begin : g_bad_width
    $error("lfsr_core: LFSR_W must be 8, 16, 24 or 32");
  end

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;
  logic [LFSR_W-1:0] shift_val;

  // One Galois step: shift right, fold the outgoing bit back in at the tap positions.
  genvar gi;
  for (gi = 0; gi < LFSR_W; gi++) begin : g_shift
    if (gi == LFSR_W - 1) begin : g_top
      assign shift_val[gi] = TAPS[gi] & q_q[0];
    end else begin : g_mid
      assign shift_val[gi] = q_q[gi+1] ^ (TAPS[gi] & q_q[0]);
    end
  end

  // Next value: a load wins over the free-running advance.
  always_comb begin
    q_d = shift_val;
    if (load) begin
      q_d = (load_val == '0) ? SEED : load_val;
    end
  end

  // LFSR register, returns to SEED on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_rand_range.sv
// Uniform random value in [RANGE_MIN, RANGE_MAX] for game logic.
// Draws the low K bits of a free-running LFSR and rejects values outside the
// span; after MAX_TRIES rejections the last draw is folded back into range and
// the result is flagged as a fallback.
module lfsr_rand_range
  import rand_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter int                OUT_W     = 3,
  parameter int                RANGE_MIN = 1,
  parameter int                RANGE_MAX = 4,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 8
) (
  input logic              clk,
  input logic              rst,
  lfsr_rand_range_if.slave bus
);

  localparam int SPAN  = RANGE_MAX - RANGE_MIN + 1;
  localparam int K     = clog2(SPAN);
  localparam int TRY_W = (MAX_TRIES > 1) ? clog2(MAX_TRIES) : 1;
  // One extra bit so a span of exactly 2**OUT_W still compares correctly.
  localparam int CMP_W = OUT_W + 1;

  localparam logic [CMP_W-1:0] SPAN_C   = CMP_W'(SPAN);
  localparam logic [OUT_W-1:0] MIN_C    = OUT_W'(RANGE_MIN);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  if (RANGE_MIN < 0) begin : g_bad_min
    $error("lfsr_rand_range: RANGE_MIN must be non-negative");
  end

  if (RANGE_MAX < RANGE_MIN) begin : g_bad_order
    $error("lfsr_rand_range: RANGE_MAX must be >= RANGE_MIN");
  end

  if (RANGE_MAX >= (1 << OUT_W)) begin : g_bad_max
    $error("lfsr_rand_range: RANGE_MAX must fit in OUT_W bits");
  end

  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("lfsr_rand_range: MAX_TRIES must be at least 1");
  end

  if (K > LFSR_W) begin : g_bad_k
    $error("lfsr_rand_range: range needs more bits than the LFSR provides");
  end

  logic [LFSR_W-1:0] lfsr_val;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.seed_load),
    .load_val (bus.seed_in),
    .q        (lfsr_val)
  );

  // Only the low K bits feed the candidate; the rest only matter to the LFSR itself.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_val;

  // Candidate draw from the current (pre-edge) LFSR value.
  logic [CMP_W-1:0] cand;

  if (K == 0) begin : g_cand_zero
    assign cand = '0;
  end else begin : g_cand
    assign cand = CMP_W'(lfsr_val[K-1:0]);
  end

  logic             accept;
  logic [OUT_W-1:0] accept_val;
  logic [OUT_W-1:0] fold_val;

  // Since 2**K < 2*SPAN, a rejected candidate minus SPAN is always in range.
  assign accept     = (cand < SPAN_C);
  assign accept_val = MIN_C + cand[OUT_W-1:0];
  assign fold_val   = MIN_C + OUT_W'(cand - SPAN_C);

  state_t           state_q, state_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0] rand_out_q, rand_out_d;
  logic             valid_q, valid_d;
  logic             fallback_q, fallback_d;

  // Next-state and result logic: requests start a draw, each DRAW cycle either
  // accepts, retries, or falls back on the final try.
  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    rand_out_d = rand_out_q;
    valid_d    = 1'b0;
    fallback_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (accept) begin
          rand_out_d = accept_val;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end else if (tries_q == LAST_TRY) begin
          rand_out_d = fold_val;
          valid_d    = 1'b1;
          fallback_d = 1'b1;
          state_d    = IDLE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, try counter and output registers; reset abandons any draw in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tries_q    <= '0;
      rand_out_q <= '0;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      rand_out_q <= rand_out_d;
      valid_q    <= valid_d;
      fallback_q <= fallback_d;
    end
  end

  assign bus.rand_out   = rand_out_q;
  assign bus.rand_valid = valid_q;
  assign bus.busy       = (state_q == DRAW);
  assign bus.fallback   = fallback_q;

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Bench for lfsr_rand_range: three instances share clock, reset and seed inputs.
//   unit 0: range 1..4, 8 tries (power-of-two span)
//   unit 1: range 1..5, 8 tries
//   unit 2: range 1..5, 2 tries (fallback path is frequent)
// A transaction-level model predicts each result from the LFSR sequence and
// the draw/reject rules; every cycle the DUT outputs are compared with it.
module tb_lfsr_rand_range;

  localparam int          NDUT = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] POLY = 16'hB400;

  function automatic int max_of(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic int span_of(input int d);
    return max_of(d);  // RANGE_MIN is 1 for every unit
  endfunction

  function automatic int tries_of(input int d);
    return (d == 2) ? 2 : 8;
  endfunction

  function automatic int kbits_of(input int d);
    int k;
    k = 0;
    while ((1 << k) < span_of(d)) k++;
    return k;
  endfunction

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shift Galois form
  function automatic logic [15:0] galois_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req_v   [NDUT];
  logic [2:0]  out_v   [NDUT];
  logic        valid_v [NDUT];
  logic        busy_v  [NDUT];
  logic        fb_v    [NDUT];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      lfsr_rand_range_if #(.LFSR_W(16), .OUT_W(3)) bus ();
      assign bus.seed_load = seed_load;
      assign bus.seed_in   = seed_in;
      assign bus.req       = req_v[gi];
      assign out_v[gi]     = bus.rand_out;
      assign valid_v[gi]   = bus.rand_valid;
      assign busy_v[gi]    = bus.busy;
      assign fb_v[gi]      = bus.fallback;

      lfsr_rand_range #(
        .LFSR_W    (16),
        .OUT_W     (3),
        .RANGE_MIN (1),
        .RANGE_MAX (max_of(gi)),
        .SEED      (16'hACE1),
        .MAX_TRIES (tries_of(gi))
      ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
      );
    end
  endgenerate

  // Reference model state
  logic [15:0] m_lfsr;
  bit          pend     [NDUT];
  int          ndraw    [NDUT];
  logic [2:0]  e_out    [NDUT];
  bit          e_valid  [NDUT];
  bit          e_fb     [NDUT];
  int          accepted [NDUT];
  int          valids   [NDUT];
  int          fb_seen  [NDUT];
  int          acc_cyc  [NDUT];

  int  cyc;
  int  n_checks;
  int  n_err;
  int  hist0 [8];
  bit  hist_on;
  bit  b2b_on;
  int  last_valid0;
  bit  rec_on;
  logic [2:0] seq_cur [$];
  logic [2:0] seq_a   [$];
  logic [2:0] seq_b   [$];
  bit  pat [64];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED;
    for (int d = 0; d < NDUT; d++) begin
      pend[d]    = 1'b0;
      e_out[d]   = 3'd0;
      e_valid[d] = 1'b0;
      e_fb[d]    = 1'b0;
    end
  endtask

  // One clock: update the model with the inputs the DUT sampled, then compare.
  task automatic step_cycle();
    logic [15:0] pre;
    int c;
    int lat;
    @(posedge clk);
    cyc++;
    pre = m_lfsr;
    if (rst)                m_lfsr = SEED;
    else if (seed_load)     m_lfsr = (seed_in == 16'h0) ? SEED : seed_in;
    else                    m_lfsr = galois_next(pre);
    for (int d = 0; d < NDUT; d++) begin
      e_valid[d] = 1'b0;
      e_fb[d]    = 1'b0;
      if (rst) begin
        pend[d]  = 1'b0;
        e_out[d] = 3'd0;
      end else if (pend[d]) begin
        ndraw[d]++;
        c = int'(pre) % (1 << kbits_of(d));
        if (c < span_of(d)) begin
          e_out[d]   = 3'(1 + c);
          e_valid[d] = 1'b1;
          pend[d]    = 1'b0;
        end else if (ndraw[d] == tries_of(d)) begin
          e_out[d]   = 3'(1 + c - span_of(d));
          e_valid[d] = 1'b1;
          e_fb[d]    = 1'b1;
          pend[d]    = 1'b0;
        end
      end else if (req_v[d]) begin
        pend[d]  = 1'b1;
        ndraw[d] = 0;
        accepted[d]++;
        acc_cyc[d] = cyc;
      end
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_val($sformatf("valid%0d", d), valid_v[d], e_valid[d]);
      check_val($sformatf("busy%0d", d), busy_v[d], pend[d]);
      check_val($sformatf("out%0d", d), out_v[d], e_out[d]);
      check_val($sformatf("fallback%0d", d), fb_v[d], e_fb[d]);
      if (valid_v[d] === 1'b1) begin
        valids[d]++;
        if (fb_v[d] === 1'b1) fb_seen[d]++;
        lat = cyc - acc_cyc[d];
        $display("unit%0d cyc=%0d value=%0d fallback=%0d latency=%0d",
                 d, cyc, out_v[d], fb_v[d], lat);
        check_val($sformatf("range%0d", d),
                  (out_v[d] >= 3'd1) && (int'(out_v[d]) <= max_of(d)), 1);
        if (d == 0) begin
          check_val("lat_pow2", lat, 1);
          if (hist_on) hist0[out_v[0]]++;
          if (b2b_on) begin
            if (last_valid0 >= 0) check_val("b2b_gap", cyc - last_valid0, 2);
            last_valid0 = cyc;
          end
        end else begin
          check_val($sformatf("lat_bound%0d", d), (lat >= 1) && (lat <= tries_of(d)), 1);
        end
        if (d == 1 && rec_on) seq_cur.push_back(out_v[1]);
      end
    end
  endtask

  task automatic idle_inputs();
    seed_load = 1'b0;
    for (int d = 0; d < NDUT; d++) req_v[d] = 1'b0;
  endtask

  task automatic run_seq();
    seed_in   = 16'h1234;
    seed_load = 1'b1;
    step_cycle();
    seed_load = 1'b0;
    seq_cur.delete();
    rec_on = 1'b1;
    for (int i = 0; i < 64; i++) begin
      req_v[1] = pat[i];
      step_cycle();
    end
    req_v[1] = 1'b0;
    repeat (12) step_cycle();
    rec_on = 1'b0;
  endtask

  initial begin
    int a1, v0, vv1, total;
    n_checks = 0; n_err = 0; cyc = 0;
    hist_on = 0; b2b_on = 0; rec_on = 0; last_valid0 = -1;
    for (int v = 0; v < 8; v++) hist0[v] = 0;
    for (int d = 0; d < NDUT; d++) begin
      accepted[d] = 0; valids[d] = 0; fb_seen[d] = 0; acc_cyc[d] = 0; ndraw[d] = 0;
    end
    rst = 1'b1;
    seed_in = 16'h0;
    idle_inputs();
    model_reset();

    // Reset state
    repeat (2) step_cycle();
    check_val("rst_lfsr", g_dut[0].dut.u_lfsr.q, SEED);
    rst = 1'b0;
    repeat (3) step_cycle();

    // Random spaced requests: 1000 on the 1..4 unit, 2000 on the 1..5 unit,
    // random traffic on the 2-try unit, occasional reseeds (some zero).
    hist_on = 1'b1;
    for (int i = 0; i < 40000 && (accepted[0] < 1000 || accepted[1] < 2000); i++) begin
      req_v[0] = (accepted[0] < 1000) && ($urandom_range(0, 1) == 0);
      req_v[1] = (accepted[1] < 2000) && ($urandom_range(0, 1) == 0);
      req_v[2] = ($urandom_range(0, 1) == 0);
      seed_load = ($urandom_range(0, 299) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      step_cycle();
    end
    check_val("traffic_done", (accepted[0] == 1000) && (accepted[1] == 2000), 1);
    idle_inputs();
    repeat (12) step_cycle();
    hist_on = 1'b0;
    total = 0;
    for (int v = 0; v < 8; v++) total += hist0[v];
    check_val("hist_total", total, 1000);
    for (int v = 1; v <= 4; v++) begin
      $display("histogram value=%0d count=%0d", v, hist0[v]);
      check_val($sformatf("hist_%0d", v), (hist0[v] >= 190) && (hist0[v] <= 310), 1);
    end
    check_val("pow2_no_fallback", fb_seen[0], 0);
    $display("fallbacks unit1=%0d unit2=%0d", fb_seen[1], fb_seen[2]);

    // Zero seed substitution, then reproducible sequences from the same seed
    seed_in   = 16'h0;
    seed_load = 1'b1;
    step_cycle();
    seed_load = 1'b0;
    check_val("zero_seed", g_dut[0].dut.u_lfsr.q, SEED);
    for (int i = 0; i < 64; i++) pat[i] = ($urandom_range(0, 2) == 0);
    run_seq();
    seq_a = seq_cur;
    run_seq();
    seq_b = seq_cur;
    check_val("seq_nonempty", seq_a.size() > 0, 1);
    check_val("seq_len", seq_b.size(), seq_a.size());
    for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++) begin
      check_val($sformatf("seq_%0d", i), seq_b[i], seq_a[i]);
    end

    // req held high for 200 cycles
    b2b_on = 1'b1;
    last_valid0 = -1;
    v0  = valids[0];
    a1  = accepted[1];
    vv1 = valids[1];
    req_v[0] = 1'b1;
    req_v[1] = 1'b1;
    repeat (200) step_cycle();
    idle_inputs();
    b2b_on = 1'b0;
    check_val("held_valid_cnt0", valids[0] - v0, 100);
    repeat (12) step_cycle();
    check_val("held_valid_cnt1", valids[1] - vv1, accepted[1] - a1);

    // Reset while busy: seed forces a reject on the first draw of unit 1
    seed_in   = 16'h0007;
    seed_load = 1'b1;
    req_v[1]  = 1'b1;
    step_cycle();
    seed_load = 1'b0;
    req_v[1]  = 1'b0;
    step_cycle();
    check_val("pre_rst_busy", busy_v[1], 1);
    rst = 1'b1;
    #1;
    check_val("rst_busy_now", busy_v[1], 0);
    check_val("rst_valid_now", valid_v[1], 0);
    check_val("rst_out_now", out_v[1], 0);
    check_val("rst_lfsr_now", g_dut[1].dut.u_lfsr.q, SEED);
    model_reset();
    repeat (2) step_cycle();
    rst = 1'b0;
    repeat (20) step_cycle();

    // Short burst after reset to confirm normal operation resumes
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < NDUT; d++) req_v[d] = ($urandom_range(0, 1) == 0);
      step_cycle();
    end
    idle_inputs();
    repeat (12) step_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
